// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - widths, reset PC and FSM encodings for the fetch sequencer
package fetch_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] FC_RESET_PC = 32'h0000_0000;

  // One outstanding request: BOOT -> REQ -> WAIT -> REQ, DROP swallows a stale response
  typedef enum logic [1:0] {
    FC_BOOT = 2'd0,
    FC_REQ  = 2'd1,
    FC_WAIT = 2'd2,
    FC_DROP = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory request/response bus
import fetch_ctrl_pkg::*;

interface fetch_ctrl_if;

  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [INST_WIDTH-1:0] imem_rdata_i;

  // Fetch side issues requests and receives grant/response
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  // Memory side accepts requests and returns instruction words
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and IMEM fetch sequencer; FETCH_PERF_CNT_EN adds stall/drop counters
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = FC_RESET_PC
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  trap_i,
  input  logic [ADDR_WIDTH-1:0] trap_pc_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_pc_i,
  fetch_ctrl_if.master          imem,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_drop_cnt_o
`endif
);

  fc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] gaddr_q, gaddr_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic                  buf_full;
  logic                  req;
  logic                  fire;
  logic                  capture;

  // Redirect priority mux (trap beats branch) and request/response qualifiers
  always_comb begin
    redirect = trap_i | branch_i;
    target   = trap_i ? trap_pc_i : branch_pc_i;
    // Holding an instruction decode won't take: a new response would have nowhere to go
    buf_full = inst_valid_q & stall_i;
    req      = (state_q == FC_REQ) & ~buf_full;
    fire     = req & imem.imem_gnt_i;
    // A redirect in the same cycle as the response makes that response stale
    capture  = (state_q == FC_WAIT) & imem.imem_rvalid_i & ~redirect;
  end

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FC_BOOT;
      pc_q         <= RESET_PC;
      gaddr_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      gaddr_q      <= gaddr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Next-state logic; a response in BOOT/REQ is a leftover from before reset and is ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FC_BOOT: state_d = FC_REQ;
      FC_REQ: begin
        if (fire) state_d = redirect ? FC_DROP : FC_WAIT;
      end
      FC_WAIT: begin
        if (imem.imem_rvalid_i) state_d = FC_REQ;
        else if (redirect)      state_d = FC_DROP;
      end
      FC_DROP: begin
        if (imem.imem_rvalid_i) state_d = FC_REQ;
      end
      default: state_d = FC_BOOT;
    endcase
  end

  // PC update, granted-address tracking and instruction buffer
  always_comb begin
    pc_d         = pc_q;
    gaddr_d      = gaddr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    if (redirect)  pc_d = target;
    else if (fire) pc_d = pc_q + ADDR_WIDTH'(4);

    if (fire) gaddr_d = pc_q;

    // Flush on redirect regardless of stall; otherwise a fresh word overwrites, an idle cycle consumes
    if (redirect) begin
      inst_valid_d = 1'b0;
    end else if (capture) begin
      inst_valid_d = 1'b1;
      inst_d       = imem.imem_rdata_i;
      inst_pc_d    = gaddr_q;
    end else if (!stall_i) begin
      inst_valid_d = 1'b0;
    end
  end

  // Output drive
  always_comb begin
    imem.imem_req_o  = req;
    imem.imem_addr_o = pc_q;
    pc_o             = pc_q;
    inst_valid_o     = inst_valid_q;
    inst_o           = inst_q;
    inst_pc_o        = inst_pc_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic        drop_rsp;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Count held-instruction stall cycles and responses thrown away after a redirect
  always_comb begin
    drop_rsp    = imem.imem_rvalid_i &
                  ((state_q == FC_DROP) | ((state_q == FC_WAIT) & redirect));
    stall_cnt_d = stall_cnt_q + {31'd0, buf_full};
    drop_cnt_d  = drop_cnt_q + {31'd0, drop_rsp};
  end

  // Counter flops, free-running and wrapping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_drop_cnt_o  = drop_cnt_q;
`else
  // Counters absent in this build
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_inst_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic        branch_i;
  logic [31:0] branch_pc_i;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  logic        gnt_en;
  logic        pend;
  logic        hold;
  int          cnt;
  int          lat;
  logic [31:0] rsp_addr;

  logic        prev_valid;
  logic [31:0] prev_pc;

  int          checks;
  int          errors;

  logic [31:0] exp_addr_q[$];
  exp_inst_t   exp_inst_q[$];

  fetch_ctrl_if bus();

  fetch_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .stall_i      (stall_i),
    .trap_i       (trap_i),
    .trap_pc_i    (trap_pc_i),
    .branch_i     (branch_i),
    .branch_pc_i  (branch_pc_i),
    .imem         (bus.master),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  assign bus.imem_gnt_i    = bus.imem_req_o & gnt_en;
  assign bus.imem_rvalid_i = pend & (cnt == 0) & ~hold;
  assign bus.imem_rdata_i  = mem_word(rsp_addr);

  task automatic push_fetch(input logic [31:0] a);
    exp_inst_t e;
    e.pc   = a;
    e.inst = mem_word(a);
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(e);
  endtask

  // One clock: sample at negedge against the scoreboards, then step the memory model
  task automatic tick();
    logic        fire;
    logic        rv;
    logic [31:0] faddr;
    logic [31:0] ea;
    exp_inst_t   e;
    gnt_en = (exp_addr_q.size() != 0);
    @(negedge clk_i);
    fire  = bus.imem_req_o & bus.imem_gnt_i;
    rv    = bus.imem_rvalid_i;
    faddr = bus.imem_addr_o;
    if (fire) begin
      checks++;
      ea = exp_addr_q.pop_front();
      if (faddr !== ea) begin
        errors++;
        $display("FAIL req_addr: got %h, expected %h", faddr, ea);
      end
    end
    if (inst_valid_o && (!prev_valid || inst_pc_o !== prev_pc)) begin
      checks++;
      if (exp_inst_q.size() == 0) begin
        errors++;
        $display("FAIL inst_unexpected: got pc=%h inst=%h, expected none", inst_pc_o, inst_o);
      end else begin
        e = exp_inst_q.pop_front();
        if (inst_pc_o !== e.pc || inst_o !== e.inst) begin
          errors++;
          $display("FAIL inst_out: got pc=%h inst=%h, expected pc=%h inst=%h",
                   inst_pc_o, inst_o, e.pc, e.inst);
        end
      end
    end
    prev_valid = inst_valid_o;
    prev_pc    = inst_pc_o;
    @(posedge clk_i);
    #1;
    if (rv) pend = 1'b0;
    if (fire) begin
      pend     = 1'b1;
      rsp_addr = faddr;
      cnt      = lat - 1;
    end else if (pend && cnt != 0) begin
      cnt = cnt - 1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || exp_inst_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending addr=%0d inst=%0d, expected 0/0",
               name, exp_addr_q.size(), exp_inst_q.size());
    end
  endtask

  task automatic wait_fired(input string name);
    int n;
    n = 0;
    while (exp_addr_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_fire: pending addr=%0d, expected 0", name, exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    int edges;
    tick();
    tick();
    checks += 5;
    if (pc_o !== 32'h0)           begin errors++; $display("FAIL rst_pc: got %h, expected 0", pc_o); end
    if (bus.imem_req_o !== 1'b0)  begin errors++; $display("FAIL rst_req: got %b, expected 0", bus.imem_req_o); end
    if (inst_valid_o !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b, expected 0", inst_valid_o); end
    if (inst_o !== 32'h0)         begin errors++; $display("FAIL rst_inst: got %h, expected 0", inst_o); end
    if (inst_pc_o !== 32'h0)      begin errors++; $display("FAIL rst_inst_pc: got %h, expected 0", inst_pc_o); end
    push_fetch(32'h0);
    push_fetch(32'h4);
    push_fetch(32'h8);
    rst_ni = 1'b1;
    edges  = 0;
    while (!inst_valid_o && edges < 10) begin
      tick();
      edges++;
    end
    checks++;
    if (edges !== 3) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d cycles, expected 3", edges);
    end
    drain("boot");
  endtask

  task automatic test_stall();
    int n;
    push_fetch(32'hC);
    n = 0;
    while (!inst_valid_o && n < 10) begin
      tick();
      n++;
    end
    stall_i = 1'b1;
    exp_addr_q.push_back(32'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 4;
      if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req: got %b, expected 0", bus.imem_req_o); end
      if (inst_valid_o !== 1'b1)   begin errors++; $display("FAIL stall_valid: got %b, expected 1", inst_valid_o); end
      if (inst_o !== mem_word(32'hC) || inst_pc_o !== 32'hC) begin
        errors++;
        $display("FAIL stall_hold: got pc=%h inst=%h, expected pc=%h inst=%h",
                 inst_pc_o, inst_o, 32'hC, mem_word(32'hC));
      end
      if (pc_o !== 32'h10)         begin errors++; $display("FAIL stall_pc: got %h, expected 10", pc_o); end
    end
    stall_i = 1'b0;
    exp_inst_q.push_back({32'h10, mem_word(32'h10)});
    drain("stall");
  endtask

  task automatic test_branch_wait();
    lat = 3;
    exp_addr_q.push_back(32'h14);
    wait_fired("branch");
    branch_i    = 1'b1;
    branch_pc_i = 32'h100;
    tick();
    branch_i = 1'b0;
    checks += 3;
    if (inst_valid_o !== 1'b0)   begin errors++; $display("FAIL branch_flush: got %b, expected 0", inst_valid_o); end
    if (pc_o !== 32'h100)        begin errors++; $display("FAIL branch_pc: got %h, expected 100", pc_o); end
    if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL branch_drop_req: got %b, expected 0", bus.imem_req_o); end
    push_fetch(32'h100);
    drain("branch");
    lat = 1;
  endtask

  task automatic test_trap_priority();
    trap_i      = 1'b1;
    trap_pc_i   = 32'h80;
    branch_i    = 1'b1;
    branch_pc_i = 32'h200;
    tick();
    trap_i   = 1'b0;
    branch_i = 1'b0;
    checks++;
    if (pc_o !== 32'h80) begin errors++; $display("FAIL trap_prio_pc: got %h, expected 80", pc_o); end
    push_fetch(32'h80);
    drain("trap");
    // Redirect on the grant cycle: the granted fetch must be discarded
    exp_addr_q.push_back(32'h84);
    branch_i    = 1'b1;
    branch_pc_i = 32'h300;
    tick();
    branch_i = 1'b0;
    push_fetch(32'h300);
    drain("gnt_redirect");
  endtask

  task automatic test_wrap();
    branch_i    = 1'b1;
    branch_pc_i = 32'hFFFF_FFFC;
    tick();
    branch_i = 1'b0;
    push_fetch(32'hFFFF_FFFC);
    push_fetch(32'h0);
    drain("wrap");
    checks++;
    if (pc_o !== 32'h4) begin errors++; $display("FAIL wrap_pc: got %h, expected 4", pc_o); end
  endtask

  task automatic test_reset_mid_wait();
    hold = 1'b1;
    branch_i    = 1'b1;
    branch_pc_i = 32'h40;
    tick();
    branch_i = 1'b0;
    exp_addr_q.push_back(32'h40);
    wait_fired("rstwait");
    rst_ni = 1'b0;
    tick();
    checks += 3;
    if (pc_o !== 32'h0)          begin errors++; $display("FAIL rstwait_pc: got %h, expected 0", pc_o); end
    if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rstwait_req: got %b, expected 0", bus.imem_req_o); end
    if (inst_valid_o !== 1'b0)   begin errors++; $display("FAIL rstwait_valid: got %b, expected 0", inst_valid_o); end
    rst_ni = 1'b1;
    tick();
    hold = 1'b0;
    tick();
    push_fetch(32'h0);
    drain("rstwait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_ni      = 1'b0;
    stall_i     = 1'b0;
    trap_i      = 1'b0;
    trap_pc_i   = '0;
    branch_i    = 1'b0;
    branch_pc_i = '0;
    gnt_en      = 1'b0;
    pend        = 1'b0;
    hold        = 1'b0;
    cnt         = 0;
    lat         = 1;
    rsp_addr    = '0;
    prev_valid  = 1'b0;
    prev_pc     = '0;

    test_reset();
    test_stall();
    test_branch_wait();
    test_trap_priority();
    test_wrap();
    test_reset_mid_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
